// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI3 write-path widths and enumerations
package axi_pkg;

    localparam int ID_W    = 4;
    localparam int LEN_W   = 4;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int STRB_W  = 4;
    localparam int RESP_W  = 2;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } wr_arb_state_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
// A lone requester always wins; on a tie the prio input decides.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic       gnt_idx_o,
    output logic       any_o
);

    always_comb begin
        any_o     = |req_i;
        gnt_idx_o = (req_i == 2'b11) ? prio_i : req_i[1];
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-master round-robin arbiter for a shared AXI3 write port
// One complete AW/W/B transaction owns the slave port at a time.
module axi_wr_arbiter
    import axi_pkg::*;
#(
    parameter int NM = 2,
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic                           aclk_i,
    input  logic                           areset_i,
    input  logic [NM-1:0][ID_W-1:0]        m_awid_i,
    input  logic [NM-1:0][AW-1:0]          m_awaddr_i,
    input  logic [NM-1:0][LEN_W-1:0]       m_awlen_i,
    input  logic [NM-1:0][SIZE_W-1:0]      m_awsize_i,
    input  logic [NM-1:0][BURST_W-1:0]     m_awburst_i,
    input  logic [NM-1:0]                  m_awvalid_i,
    output logic [NM-1:0]                  m_awready_o,
    input  logic [NM-1:0][ID_W-1:0]        m_wid_i,
    input  logic [NM-1:0][DW-1:0]          m_wdata_i,
    input  logic [NM-1:0][STRB_W-1:0]      m_wstrb_i,
    input  logic [NM-1:0]                  m_wlast_i,
    input  logic [NM-1:0]                  m_wvalid_i,
    output logic [NM-1:0]                  m_wready_o,
    output logic [ID_W-1:0]                m_bid_o,
    output logic [RESP_W-1:0]              m_bresp_o,
    output logic [NM-1:0]                  m_bvalid_o,
    input  logic [NM-1:0]                  m_bready_i,
    output logic [ID_W-1:0]                s_awid_o,
    output logic [AW-1:0]                  s_awaddr_o,
    output logic [LEN_W-1:0]               s_awlen_o,
    output logic [SIZE_W-1:0]              s_awsize_o,
    output logic [BURST_W-1:0]             s_awburst_o,
    output logic                           s_awvalid_o,
    input  logic                           s_awready_i,
    output logic [ID_W-1:0]                s_wid_o,
    output logic [DW-1:0]                  s_wdata_o,
    output logic [STRB_W-1:0]              s_wstrb_o,
    output logic                           s_wlast_o,
    output logic                           s_wvalid_o,
    input  logic                           s_wready_i,
    input  logic [ID_W-1:0]                s_bid_i,
    input  logic [RESP_W-1:0]              s_bresp_i,
    input  logic                           s_bvalid_i,
    output logic                           s_bready_o,
    output logic                           grant_o,
    output logic                           busy_o,
    output logic                           len_err_o
);

    wr_arb_state_t    r_state;
    wr_arb_state_t    w_state_nxt;
    logic             r_grant;
    logic             r_prio;
    logic [LEN_W-1:0] r_beat;
    logic [LEN_W-1:0] r_len;
    logic             w_pick;
    logic             w_any;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;

    rr_pick2 u_pick (
        .req_i     (m_awvalid_i[1:0]),
        .prio_i    (r_prio),
        .gnt_idx_o (w_pick),
        .any_o     (w_any)
    );

    assign grant_o = r_grant;
    assign busy_o  = (r_state != IDLE);

    // Every channel is gated by state so idle/foreign channels read as all-zero.
    always_comb begin
        w_state_nxt = r_state;
        w_aw_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_b_hs      = 1'b0;
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        m_bid_o     = '0;
        m_bresp_o   = '0;
        s_awid_o    = '0;
        s_awaddr_o  = '0;
        s_awlen_o   = '0;
        s_awsize_o  = '0;
        s_awburst_o = '0;
        s_awvalid_o = 1'b0;
        s_wid_o     = '0;
        s_wdata_o   = '0;
        s_wstrb_o   = '0;
        s_wlast_o   = 1'b0;
        s_wvalid_o  = 1'b0;
        s_bready_o  = 1'b0;
        len_err_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = ADDR;
            end
            ADDR: begin
                s_awid_o             = m_awid_i[r_grant];
                s_awaddr_o           = m_awaddr_i[r_grant];
                s_awlen_o            = m_awlen_i[r_grant];
                s_awsize_o           = m_awsize_i[r_grant];
                s_awburst_o          = m_awburst_i[r_grant];
                s_awvalid_o          = m_awvalid_i[r_grant];
                m_awready_o[r_grant] = s_awready_i;
                w_aw_hs              = m_awvalid_i[r_grant] & s_awready_i;
                if (w_aw_hs) w_state_nxt = DATA;
            end
            DATA: begin
                s_wid_o             = m_wid_i[r_grant];
                s_wdata_o           = m_wdata_i[r_grant];
                s_wstrb_o           = m_wstrb_i[r_grant];
                s_wlast_o           = m_wlast_i[r_grant];
                s_wvalid_o          = m_wvalid_i[r_grant];
                m_wready_o[r_grant] = s_wready_i;
                w_w_hs              = m_wvalid_i[r_grant] & s_wready_i;
                if (w_w_hs) begin
                    // Flags both a short burst (early WLAST) and a long one (missing WLAST).
                    len_err_o = m_wlast_i[r_grant] ? (r_beat != r_len) : (r_beat == r_len);
                    if (m_wlast_i[r_grant]) w_state_nxt = RESP;
                end
            end
            RESP: begin
                m_bvalid_o[r_grant] = s_bvalid_i;
                m_bid_o             = s_bid_i;
                m_bresp_o           = s_bresp_i;
                s_bready_o          = m_bready_i[r_grant];
                w_b_hs              = s_bvalid_i & m_bready_i[r_grant];
                if (w_b_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
            r_beat  <= '0;
            r_len   <= '0;
        end else begin
            if (r_state == IDLE && w_any) r_grant <= w_pick;
            if (w_aw_hs) begin
                r_len  <= m_awlen_i[r_grant];
                r_beat <= '0;
            end
            if (w_w_hs) r_beat <= r_beat + 1'b1;
            if (w_b_hs) r_prio <= ~r_grant;
        end
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - self-checking bench for axi_wr_arbiter
module tb_axi_wr_arbiter;
    import axi_pkg::*;

    logic aclk_i = 1'b0;
    logic areset_i;
    logic [1:0][3:0]  m_awid_i;
    logic [1:0][31:0] m_awaddr_i;
    logic [1:0][3:0]  m_awlen_i;
    logic [1:0][2:0]  m_awsize_i;
    logic [1:0][1:0]  m_awburst_i;
    logic [1:0]       m_awvalid_i, m_awready_o;
    logic [1:0][3:0]  m_wid_i;
    logic [1:0][31:0] m_wdata_i;
    logic [1:0][3:0]  m_wstrb_i;
    logic [1:0]       m_wlast_i, m_wvalid_i, m_wready_o;
    logic [3:0]       m_bid_o;
    logic [1:0]       m_bresp_o;
    logic [1:0]       m_bvalid_o, m_bready_i;
    logic [3:0]       s_awid_o, s_awlen_o, s_wid_o, s_wstrb_o, s_bid_i;
    logic [31:0]      s_awaddr_o, s_wdata_o;
    logic [2:0]       s_awsize_o;
    logic [1:0]       s_awburst_o, s_bresp_i;
    logic             s_awvalid_o, s_awready_i, s_wlast_o, s_wvalid_o, s_wready_i;
    logic             s_bvalid_i, s_bready_o, grant_o, busy_o, len_err_o;

    int checks = 0;
    int errors = 0;
    int exp_prio;
    logic [1:0]  pend;
    logic [31:0] t_addr [2];
    int          t_len  [2];
    int          t_nb   [2];
    logic [3:0]  t_id   [2];

    always #5 aclk_i = ~aclk_i;

    axi_wr_arbiter #(.NM(2), .DW(32), .AW(32)) dut (
        .aclk_i(aclk_i), .areset_i(areset_i),
        .m_awid_i(m_awid_i), .m_awaddr_i(m_awaddr_i), .m_awlen_i(m_awlen_i),
        .m_awsize_i(m_awsize_i), .m_awburst_i(m_awburst_i),
        .m_awvalid_i(m_awvalid_i), .m_awready_o(m_awready_o),
        .m_wid_i(m_wid_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
        .m_wlast_i(m_wlast_i), .m_wvalid_i(m_wvalid_i), .m_wready_o(m_wready_o),
        .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o), .m_bvalid_o(m_bvalid_o),
        .m_bready_i(m_bready_i),
        .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o), .s_awlen_o(s_awlen_o),
        .s_awsize_o(s_awsize_o), .s_awburst_o(s_awburst_o),
        .s_awvalid_o(s_awvalid_o), .s_awready_i(s_awready_i),
        .s_wid_o(s_wid_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
        .s_wlast_o(s_wlast_o), .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i),
        .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i),
        .s_bready_o(s_bready_o),
        .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: a lone requester wins, a tie goes to the remembered priority.
    function automatic int pick();
        if (pend == 2'b11) return exp_prio;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic present(input int m, input logic [31:0] addr, input int len, input int nb);
        t_addr[m] = addr;
        t_len[m]  = len;
        t_nb[m]   = nb;
        t_id[m]   = 4'($urandom);
        m_awaddr_i[m]  = addr;
        m_awlen_i[m]   = 4'(len);
        m_awid_i[m]    = t_id[m];
        m_awsize_i[m]  = 3'd2;
        m_awburst_i[m] = INCR;
        m_awvalid_i[m] = 1'b1;
        pend[m] = 1'b1;
    endtask

    task automatic do_reset();
        areset_i = 1'b1;
        m_awvalid_i = '0; m_wvalid_i = '0; m_wlast_i = '0; m_bready_i = '0;
        s_awready_i = 1'b0; s_wready_i = 1'b0; s_bvalid_i = 1'b0;
        @(posedge aclk_i); #1;
        areset_i = 1'b0;
        #4;
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_len_err", len_err_o, 0);
        chk("rst_valid_ready", {m_awready_o, m_wready_o, m_bvalid_o, s_awvalid_o, s_wvalid_o, s_bready_o}, 0);
        chk("rst_awaddr", s_awaddr_o, 0);
        chk("rst_wdata", s_wdata_o, 0);
        chk("rst_bid", {m_bid_o, m_bresp_o}, 0);
        @(posedge aclk_i); #1;
        exp_prio = 0;
        pend = 2'b00;
    endtask

    task automatic serve(input int m, input int awr_dly, input int b_dly, input int br_dly,
                         input bit rnd_w, input int abort_at, output int cyc);
        int o, n, b, nb, na, nw;
        bit hs, last, exp_err;
        logic [1:0] exp_resp;
        o = 1 - m;
        nb = t_nb[m];
        cyc = 0;
        m_wvalid_i[m] = 1'b1; m_wdata_i[m] = $urandom; m_wstrb_i[m] = 4'hf;
        m_wid_i[m] = t_id[m]; m_wlast_i[m] = (nb == 1);
        m_wvalid_i[o] = 1'b1; m_wdata_i[o] = $urandom; m_wlast_i[o] = 1'b1;
        s_wready_i = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 60) begin
            s_awready_i = (n >= awr_dly);
            #4;
            chk("early_wready", m_wready_o, 0);
            chk("w_before_aw", s_wvalid_o, 0);
            if (s_awvalid_o) begin
                chk("grant", grant_o, m);
                chk("aw_addr", s_awaddr_o, t_addr[m]);
                chk("aw_len", s_awlen_o, t_len[m]);
                chk("aw_id", s_awid_o, t_id[m]);
                chk("aw_ready", m_awready_o, s_awready_i ? 32'(1 << m) : 32'd0);
                hs = s_awready_i;
            end
            @(posedge aclk_i); #1;
            n++;
        end
        na = n;
        chk("aw_timeout", hs, 1);
        s_awready_i = 1'b0;
        m_awvalid_i[m] = 1'b0;
        pend[m] = 1'b0;
        b = 0; n = 0;
        while (b < nb && n < 400) begin
            if (b == abort_at) begin
                do_reset();
                return;
            end
            s_wready_i = rnd_w ? ($urandom_range(0, 2) != 0) : 1'b1;
            #4;
            last = (b == nb - 1);
            exp_err = s_wready_i && (last ? ((b % 16) != t_len[m]) : ((b % 16) == t_len[m]));
            chk("w_valid", s_wvalid_o, 1);
            chk("w_data", s_wdata_o, m_wdata_i[m]);
            chk("w_last", s_wlast_o, last);
            chk("w_ready", m_wready_o, s_wready_i ? 32'(1 << m) : 32'd0);
            chk("len_err", len_err_o, exp_err);
            @(posedge aclk_i); #1;
            if (s_wready_i) begin
                b++;
                m_wdata_i[m] = $urandom;
                m_wlast_i[m] = (b == nb - 1);
                m_wdata_i[o] = $urandom;
            end
            n++;
        end
        nw = n;
        chk("w_timeout", b, nb);
        m_wvalid_i = '0; m_wlast_i = '0; s_wready_i = 1'b0;
        exp_resp = 2'($urandom);
        s_bid_i = t_id[m]; s_bresp_i = exp_resp;
        hs = 0; n = 0;
        while (!hs && n < 60) begin
            s_bvalid_i = (n >= b_dly);
            m_bready_i[m] = (n >= br_dly);
            m_bready_i[o] = 1'b1;
            #4;
            chk("b_valid", m_bvalid_o, s_bvalid_i ? 32'(1 << m) : 32'd0);
            chk("b_ready", s_bready_o, m_bready_i[m]);
            if (s_bvalid_i) begin
                chk("b_id", m_bid_o, t_id[m]);
                chk("b_resp", m_bresp_o, exp_resp);
            end
            hs = s_bvalid_i && m_bready_i[m];
            @(posedge aclk_i); #1;
            n++;
        end
        chk("b_timeout", hs, 1);
        s_bvalid_i = 1'b0; m_bready_i = '0;
        if (hs) exp_prio = o;
        cyc = na + nw + n;
        #4;
        chk("idle_busy", busy_o, 0);
        chk("idle_valid", {s_awvalid_o, s_wvalid_o, s_bready_o, m_bvalid_o}, 0);
        @(posedge aclk_i); #1;
    endtask

    initial begin
        int cyc;
        int r;
        areset_i = 1'b1;
        m_awid_i = '0; m_awaddr_i = '0; m_awlen_i = '0; m_awsize_i = '0; m_awburst_i = '0;
        m_awvalid_i = '0; m_wid_i = '0; m_wdata_i = '0; m_wstrb_i = '0; m_wlast_i = '0;
        m_wvalid_i = '0; m_bready_i = '0; s_awready_i = 1'b0; s_wready_i = 1'b0;
        s_bid_i = '0; s_bresp_i = '0; s_bvalid_i = 1'b0;
        exp_prio = 0; pend = 2'b00;
        do_reset();

        // M0 alone, with one bubble cycle before the slave sees AWVALID
        present(0, 32'h10, 3, 4);
        #4;
        chk("lat_idle_awvalid", s_awvalid_o, 0);
        chk("lat_idle_busy", busy_o, 0);
        @(posedge aclk_i); #1;
        #4;
        chk("lat_addr_awvalid", s_awvalid_o, 1);
        chk("lat_addr_busy", busy_o, 1);
        @(posedge aclk_i); #1;
        serve(0, 0, 0, 0, 0, -1, cyc);

        // Shortest transaction: single beat, every ready high
        present(1, 32'h2000, 0, 1);
        serve(1, 0, 0, 0, 0, -1, cyc);
        chk("min_txn_cycles", cyc, 4);

        // Simultaneous requests after reset: M0, M1, then M0 again
        do_reset();
        present(0, 32'h100, 1, 2);
        present(1, 32'h200, 2, 3);
        serve(pick(), 0, 0, 0, 0, -1, cyc);
        serve(pick(), 0, 0, 0, 0, -1, cyc);
        present(0, 32'h300, 0, 1);
        present(1, 32'h400, 0, 1);
        serve(pick(), 0, 0, 0, 0, -1, cyc);
        serve(pick(), 0, 0, 0, 0, -1, cyc);

        // Early WLAST, then a long burst that wraps the beat counter
        present(0, 32'h500, 2, 2);
        serve(0, 0, 0, 0, 0, -1, cyc);
        present(1, 32'h600, 0, 18);
        serve(1, 0, 0, 0, 1, -1, cyc);

        // Slow slave AW and B, slow master BREADY
        present(0, 32'h700, 3, 4);
        serve(0, 5, 3, 2, 0, -1, cyc);
        present(1, 32'h800, 1, 2);
        serve(1, 2, 2, 5, 1, -1, cyc);

        // Reset mid-burst, then a fresh M1 request
        present(0, 32'h900, 3, 4);
        serve(0, 0, 0, 0, 0, 2, cyc);
        present(1, 32'hA00, 1, 2);
        serve(pick(), 0, 0, 0, 0, -1, cyc);

        for (int i = 0; i < 25; i++) begin
            int len;
            r = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                if (r[m] && !pend[m]) begin
                    len = $urandom_range(0, 7);
                    present(m, $urandom, len,
                            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : len + 1);
                end
            end
            serve(pick(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1, -1, cyc);
        end
        for (int k = 0; k < 2; k++) begin
            if (pend != 2'b00) serve(pick(), 0, 0, 0, 1, -1, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
